pe_array_arbiter: RTL and testbench

Time-shares the 16-lane Unified_PE array between the three PE-using engines: Linear (requester 0), Conv1D (1) and Scan (2).
- Accepts per-engine request/done handshakes.
- Picks a winner round-robin and flushes the PE accumulators by holding mode_select at IDLE.
- Drives mode_select to the winner's code and issues the winner's one-cycle start pulse.
- Holds the grant until that engine reports done or a watchdog fires.
- Replaces host-driven mode_select/start sequencing in front of the existing PE mux.

---
 rtl/mamba_ctrl_pkg.sv | 38 +++
 rtl/rr_priority_pick.sv | 31 +++
 rtl/pe_array_arbiter.sv | 141 ++++++++++++++
 tb/tb_pe_array_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mamba_ctrl_pkg.sv
// Shared control definitions for the Mamba accelerator: PE mux mode codes,
// requester indices, arbiter state encoding and small index helpers.
package mamba_ctrl_pkg;

    localparam logic [2:0] MODE_IDLE     = 3'd0;
    localparam logic [2:0] MODE_LINEAR   = 3'd1;
    localparam logic [2:0] MODE_CONV     = 3'd2;
    localparam logic [2:0] MODE_SCAN     = 3'd3;
    localparam logic [2:0] MODE_SOFTPLUS = 3'd4;

    localparam logic [1:0] REQ_LIN  = 2'd0;
    localparam logic [1:0] REQ_CONV = 2'd1;
    localparam logic [1:0] REQ_SCAN = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FLUSH = 2'd1,
        ARB_START = 2'd2,
        ARB_BUSY  = 2'd3
    } arb_state_t;

    function automatic logic [2:0] idx_to_mode(input logic [1:0] idx);
        logic [2:0] mode;
        case (idx)
            REQ_LIN:  mode = MODE_LINEAR;
            REQ_CONV: mode = MODE_CONV;
            REQ_SCAN: mode = MODE_SCAN;
            default:  mode = MODE_IDLE;
        endcase
        return mode;
    endfunction

    // Successor index modulo 3; index 3 is never produced and folds to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= REQ_SCAN) ? REQ_LIN : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick over three requesters: first set bit scanning ptr,
// ptr+1, ptr+2 (mod 3). Purely combinational.
module rr_priority_pick
    import mamba_ctrl_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    always_comb begin
        first  = (ptr > REQ_SCAN) ? REQ_LIN : ptr;
        second = next_idx(first);
        third  = next_idx(second);
        valid  = |req;
        idx    = REQ_LIN;
        if (req[first]) begin
            idx = first;
        end else if (req[second]) begin
            idx = second;
        end else if (req[third]) begin
            idx = third;
        end
    end

endmodule

// File: rtl/pe_array_arbiter.sv
// Time-shares the 16-lane PE array between Linear, Conv1D and Scan engines:
// round-robin pick, accumulator flush at MODE_IDLE, start pulse, hold until done/watchdog.
module pe_array_arbiter
    import mamba_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           req,
    input  logic [2:0]           done,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 err_clear,
    output logic [2:0]           mode_select,
    output logic [2:0]           grant,
    output logic [2:0]           start_pulse,
    output logic [1:0]           active_id,
    output logic                 busy,
    output logic                 timeout_err
);

    if (NUM_REQ != 3) begin : g_bad_num_req
        $error("pe_array_arbiter: NUM_REQ must be 3");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("pe_array_arbiter: FLUSH_CYCLES must be at least 1");
    end

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    // Handshake: req[i] is a level held until the engine sees its start_pulse
    // (or withdrawn); done[i] is a one-cycle pulse honoured only from the
    // granted engine while BUSY. There is no back-pressure on start_pulse.
    arb_state_t           state, state_n;
    logic [1:0]           ptr, ptr_n;
    logic [1:0]           active_q, active_n;
    logic [FW-1:0]        flush_cnt, flush_n;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_n;
    logic                 err_q, err_n;
    logic                 err_set;
    logic                 wd_last;
    logic                 pick_valid;
    logic [1:0]           pick_idx;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign wd_last = (timeout_limit != '0) && (wd_cnt == timeout_limit - 1'b1);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        active_n = active_q;
        flush_n  = flush_cnt;
        wd_n     = wd_cnt;
        err_set  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    active_n = pick_idx;
                    flush_n  = '0;
                    state_n  = ARB_FLUSH;
                end
            end
            ARB_FLUSH: begin
                if (!req[active_q]) begin
                    state_n = ARB_IDLE;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_n = ARB_START;
                end else begin
                    flush_n = flush_cnt + 1'b1;
                end
            end
            ARB_START: begin
                wd_n    = '0;
                state_n = ARB_BUSY;
            end
            ARB_BUSY: begin
                if (wd_cnt != '1) begin
                    wd_n = wd_cnt + 1'b1;
                end
                // A watchdog release rotates the pointer exactly like done.
                if (done[active_q]) begin
                    state_n = ARB_IDLE;
                    ptr_n   = next_idx(active_q);
                end else if (wd_last) begin
                    state_n = ARB_IDLE;
                    ptr_n   = next_idx(active_q);
                    err_set = 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
        if (err_set) begin
            err_n = 1'b1;
        end else if (err_clear) begin
            err_n = 1'b0;
        end else begin
            err_n = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= REQ_LIN;
            active_q  <= REQ_LIN;
            flush_cnt <= '0;
            wd_cnt    <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            active_q  <= active_n;
            flush_cnt <= flush_n;
            wd_cnt    <= wd_n;
            err_q     <= err_n;
        end
    end

    // Outputs decode registered state only; req/done never reach them directly.
    logic       granted;
    logic [2:0] onehot;

    assign granted     = (state == ARB_START) || (state == ARB_BUSY);
    assign onehot      = 3'b001 << active_q;
    assign mode_select = granted ? idx_to_mode(active_q) : MODE_IDLE;
    assign grant       = granted ? onehot : 3'b000;
    assign start_pulse = (state == ARB_START) ? onehot : 3'b000;
    assign active_id   = active_q;
    assign busy        = (state != ARB_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_pe_array_arbiter.sv
// Directed bench for pe_array_arbiter: start records go through an expected
// queue popped by a monitor; timing, release and error behaviour checked inline.
module tb_pe_array_arbiter;
    import mamba_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, done;
    logic [15:0] timeout_limit;
    logic        err_clear;
    logic [2:0]  mode_select, grant, start_pulse;
    logic [1:0]  active_id;
    logic        busy, timeout_err;

    logic [2:0]  req3, done3;
    logic [15:0] tl3;
    logic        err_clear3;
    logic [2:0]  mode3, grant3, start3;
    logic [1:0]  active3;
    logic        busy3, err3;

    logic [2:0]  pk_req;
    logic [1:0]  pk_ptr;
    logic        pk_valid;
    logic [1:0]  pk_idx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_array_arbiter #(.NUM_REQ(3), .FLUSH_CYCLES(1), .TIMEOUT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .timeout_limit(timeout_limit), .err_clear(err_clear),
        .mode_select(mode_select), .grant(grant), .start_pulse(start_pulse),
        .active_id(active_id), .busy(busy), .timeout_err(timeout_err)
    );

    pe_array_arbiter #(.NUM_REQ(3), .FLUSH_CYCLES(3), .TIMEOUT_W(16)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .done(done3),
        .timeout_limit(tl3), .err_clear(err_clear3),
        .mode_select(mode3), .grant(grant3), .start_pulse(start3),
        .active_id(active3), .busy(busy3), .timeout_err(err3)
    );

    rr_priority_pick u_pick_ut (
        .req(pk_req), .ptr(pk_ptr), .valid(pk_valid), .idx(pk_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every start pulse must match the next expected start record.
    always @(negedge clk) begin
        if (start_pulse != 3'b000) begin
            mon_act = {start_pulse, mode_select, grant, active_id};
            if (exp_q.size() == 0) chk("unexpected_start", {21'd0, mon_act}, 32'd0);
            else chk("start_record", {21'd0, mon_act}, {21'd0, exp_q.pop_front()});
        end
    end

    task automatic apply_reset();
        reset = 1'b1; req = '0; done = '0; err_clear = 1'b0;
        req3 = '0; done3 = '0;
        tick(); tick();
        chk("reset_outputs", {19'd0, mode_select, grant, start_pulse, active_id, busy, timeout_err}, 32'd0);
        chk("reset_busy3", {31'd0, busy3}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name, output int at);
        bit seen;
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (start_pulse != 3'b000) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Done pulsed during the third BUSY cycle after start.
    task automatic serve(input string name, input logic [2:0] dvec, input bit drop, output int at);
        wait_start(name, at);
        if (drop) req = '0;
        tick(); tick(); tick();
        done = dvec;
        tick();
        done = '0;
        chk({name, "_release"}, {26'd0, mode_select, grant}, 32'd0);
    endtask

    int  c0, c1, c2, c3;
    bit  any;
    logic [2:0] rv;
    logic       exp_v;
    logic [1:0] exp_i;

    initial begin
        reset = 1'b1; req = '0; done = '0; timeout_limit = '0; err_clear = 1'b0;
        req3 = '0; done3 = '0; tl3 = '0; err_clear3 = 1'b0;
        pk_req = '0; pk_ptr = '0;

        // Round-robin picker, all pointer/request combinations.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 8; r++) begin
                rv = 3'(r);
                pk_ptr = 2'(p); pk_req = rv;
                #1;
                exp_v = (rv != 3'b000);
                exp_i = 2'd0;
                for (int k = 2; k >= 0; k--) begin
                    if (rv[(p + k) % 3]) exp_i = 2'((p + k) % 3);
                end
                chk("pick", {29'd0, pk_valid, pk_idx}, {29'd0, exp_v, exp_i});
            end
        end

        // 1: single linear request, basic latency and release.
        apply_reset();
        exp_q.push_back({3'b001, 3'd1, 3'b001, 2'd0});
        req = 3'b001;
        tick();
        chk("t1_flush", {27'd0, busy, mode_select, start_pulse[0]}, {27'd0, 1'b1, 3'd0, 1'b0});
        tick();
        chk("t1_start", {26'd0, start_pulse, grant}, {26'd0, 3'b001, 3'b001});
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_hold", {26'd0, mode_select, grant}, {26'd0, 3'd1, 3'b001});
        end
        done = 3'b001;
        tick();
        done = '0;
        chk("t1_release", {25'd0, mode_select, grant, busy}, 32'd0);

        // 2: all requesting, rotation and spacing.
        apply_reset();
        exp_q.push_back({3'b001, 3'd1, 3'b001, 2'd0});
        exp_q.push_back({3'b010, 3'd2, 3'b010, 2'd1});
        exp_q.push_back({3'b100, 3'd3, 3'b100, 2'd2});
        exp_q.push_back({3'b001, 3'd1, 3'b001, 2'd0});
        req = 3'b111;
        serve("t2_lin", 3'b001, 1'b0, c0);
        serve("t2_conv", 3'b010, 1'b0, c1);
        serve("t2_scan", 3'b100, 1'b0, c2);
        serve("t2_lin2", 3'b001, 1'b1, c3);
        chk("t2_gap01", c1 - c0, 32'd6);
        chk("t2_gap12", c2 - c1, 32'd6);
        chk("t2_gap23", c3 - c2, 32'd6);

        // 3: foreign done ignored, pointer wraps to linear.
        apply_reset();
        exp_q.push_back({3'b100, 3'd3, 3'b100, 2'd2});
        req = 3'b100;
        wait_start("t3_scan_start", c0);
        req = '0;
        tick();
        done = 3'b011;
        tick();
        done = '0;
        chk("t3_foreign_done", {28'd0, grant, busy}, {28'd0, 3'b100, 1'b1});
        tick();
        chk("t3_still_granted", {29'd0, grant}, {29'd0, 3'b100});
        done = 3'b100;
        tick();
        done = '0;
        chk("t3_scan_release", {29'd0, grant}, 32'd0);
        exp_q.push_back({3'b001, 3'd1, 3'b001, 2'd0});
        req = 3'b101;
        wait_start("t3_lin_start", c1);
        req = '0;
        tick();
        done = 3'b001;
        tick();
        done = '0;
        chk("t3_lin_release", {31'd0, busy}, 32'd0);

        // 4: watchdog release, sticky flag, clear, set-wins.
        apply_reset();
        timeout_limit = 16'd5;
        exp_q.push_back({3'b010, 3'd2, 3'b010, 2'd1});
        req = 3'b010;
        wait_start("t4_start", c0);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_busy", {30'd0, busy, timeout_err}, {30'd0, 1'b1, 1'b0});
        end
        tick();
        chk("t4_timeout", {27'd0, mode_select, busy, timeout_err}, {27'd0, 3'd0, 1'b0, 1'b1});
        tick(); tick();
        chk("t4_sticky", {31'd0, timeout_err}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t4_cleared", {31'd0, timeout_err}, 32'd0);
        exp_q.push_back({3'b010, 3'd2, 3'b010, 2'd1});
        req = 3'b010;
        wait_start("t4_start2", c1);
        req = '0;
        tick(); tick(); tick(); tick();
        err_clear = 1'b1;
        tick();
        chk("t4_pre_timeout2", {30'd0, busy, timeout_err}, {30'd0, 1'b1, 1'b0});
        tick();
        chk("t4_set_wins", {30'd0, busy, timeout_err}, {30'd0, 1'b0, 1'b1});
        err_clear = 1'b0;
        tick();
        chk("t4_sticky2", {31'd0, timeout_err}, 32'd1);
        timeout_limit = '0;

        // 5: withdrawal during a 3-cycle flush (second instance).
        apply_reset();
        req3 = 3'b010;
        tick();
        chk("t5_flush1", {28'd0, busy3, mode3}, {28'd0, 1'b1, 3'd0});
        tick();
        chk("t5_flush2", {31'd0, busy3}, 32'd1);
        req3 = '0;
        tick();
        chk("t5_back_idle", {28'd0, busy3, grant3}, 32'd0);
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (start3 != 3'b000) any = 1'b1;
        end
        chk("t5_no_start", {31'd0, any}, 32'd0);
        req3 = 3'b110;
        tick(); tick(); tick();
        chk("t5_flush_end", {28'd0, start3, busy3}, {28'd0, 3'b000, 1'b1});
        tick();
        chk("t5_ptr_kept", {21'd0, start3, mode3, grant3, active3}, {21'd0, 3'b010, 3'd2, 3'b010, 2'd1});
        req3 = '0;
        tick();
        done3 = 3'b010;
        tick();
        done3 = '0;
        chk("t5_release", {31'd0, busy3}, 32'd0);

        // 6: reset in BUSY, then reset in START.
        apply_reset();
        exp_q.push_back({3'b001, 3'd1, 3'b001, 2'd0});
        req = 3'b001;
        wait_start("t6_start", c0);
        req = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("t6_reset_busy", {19'd0, mode_select, grant, start_pulse, active_id, busy, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t6_idle_after", {31'd0, busy}, 32'd0);
        exp_q.push_back({3'b010, 3'd2, 3'b010, 2'd1});
        req = 3'b010;
        tick();
        tick();
        reset = 1'b1;
        req = '0;
        tick();
        chk("t6_reset_start", {19'd0, mode_select, grant, start_pulse, active_id, busy, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t6_no_start", {28'd0, start_pulse, busy}, 32'd0);
        tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
